// File: rtl/gf64_pow_seq_if.sv
// ============================================================================
//  Module      : gf64_pow_seq_if
//  Description : Handshake bundle for the sequential GF(2^6) exponentiator.
//                Operand side : in_valid / in_ready / in_x / in_e
//                Result side  : out_valid / out_ready / out_y
//                Status       : busy (high while a computation is in flight
//                               or a result is waiting)
//                Modport master drives operands and result acceptance.
//                Modport slave is the exponentiator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gf64_pow_seq_if #(
  parameter int EXP_W = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_x;
  logic [EXP_W-1:0] in_e;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_y;
  logic             busy;

  modport master (
    output in_valid, in_x, in_e, out_ready,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_e, out_ready,
    output in_ready, out_valid, out_y, busy
  );
endinterface

`default_nettype wire

// File: rtl/gf64_pow_seq.sv
// ============================================================================
//  Module      : gf64_pow_seq
//  Description : Sequential GF(2^6) exponentiator, y = x^e, polynomial basis,
//                field polynomial z^6 + z + 1. MSB-first square-and-multiply,
//                one exponent bit per clock, constant latency of EXP_W cycles
//                from operand acceptance to out_valid.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - gf64_pow_seq_if.slave (operand/result handshakes,
//                       busy status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf64_pow_seq #(
  parameter int EXP_W = 6
) (
  input  wire logic      clk,
  input  wire logic      rst,
  gf64_pow_seq_if.slave  bus
);

  // Counter must hold EXP_W-1; keep at least one bit when EXP_W is 1.
  localparam int              CNT_W      = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(EXP_W - 1);
  // z^6 + z + 1, used to fold product bits 10..6 back into the field.
  localparam logic [10:0]     c_poly     = 11'b000_0100_0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       x_q,     x_d;
  logic [EXP_W-1:0] e_q,     e_d;
  logic [5:0]       acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [5:0]       out_y_q, out_y_d;

  logic [5:0]       w_sq;
  logic [5:0]       w_step;

  // Carry-less 6x6 product followed by reduction of bits 10..6, highest
  // first so that each fold can only disturb lower, not-yet-visited bits.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int k = 0; k < 6; k++) begin
      if (b[k]) p = p ^ (11'(a) << k);
    end
    for (int k = 10; k >= 6; k--) begin
      if (p[k]) p = p ^ (c_poly << (k - 6));
    end
    return p[5:0];
  endfunction

  // The exponent register is shifted left each step, so its MSB is always
  // the bit being consumed this cycle.
  assign w_sq   = gf_mul(acc_q, acc_q);
  assign w_step = e_q[EXP_W-1] ? gf_mul(w_sq, x_q) : w_sq;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_y_d = out_y_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          e_d     = bus.in_e;
          acc_d   = 6'h01;
          cnt_d   = c_cnt_init;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = w_step;
        e_d   = e_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_y_d = w_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_y_q <= out_y_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_y     = out_y_q;

endmodule

`default_nettype wire

// File: tb/tb_gf64_pow_seq.sv
// ============================================================================
//  Module      : tb_gf64_pow_seq
//  Description : Self-checking bench for gf64_pow_seq. Reference results come
//                from a shift-and-add field multiplier applied e times and
//                from a discrete-log/antilog table built around alpha = 0x02.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf64_pow_seq;

  localparam int EXP_W = 6;

  logic clk;
  logic rst;

  gf64_pow_seq_if #(.EXP_W(EXP_W)) bus ();

  gf64_pow_seq #(.EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  int exp_t [0:62];
  int log_t [0:63];

  typedef struct {
    logic [5:0]       x;
    logic [EXP_W-1:0] e;
    logic [5:0]       y;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Shift-and-add multiply: reduce after every doubling of a.
  function automatic int mul_ref(input int a, input int b);
    int r;
    int aa;
    int bb;
    r  = 0;
    aa = a;
    bb = b;
    for (int k = 0; k < 6; k++) begin
      if (bb & 1) r = r ^ aa;
      bb = bb >> 1;
      aa = aa << 1;
      if (aa & 'h40) aa = aa ^ 'h43;
    end
    return r;
  endfunction

  function automatic int pow_ref(input int x, input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = mul_ref(r, x);
    return r;
  endfunction

  function automatic int pow_log(input int x, input int e);
    if (x == 0) return (e == 0) ? 1 : 0;
    return exp_t[(log_t[x] * e) % 63];
  endfunction

  // Drive one operand, wait for the result, then handshake it out.
  task automatic run_op(input logic [5:0] x, input logic [EXP_W-1:0] e,
                        output logic [5:0] y, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    bus.in_x      = x;
    bus.in_e      = e;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    y = bus.out_y;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] y;
    int         lat;
    int         v;
    int         seen;

    checks = 0;
    errors = 0;

    v = 1;
    for (int k = 0; k < 63; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = mul_ref(v, 2);
    end
    log_t[0] = 0;

    vecs[0] = '{x: 6'h02, e: 6'd52, y: 6'h15};
    vecs[1] = '{x: 6'h01, e: 6'd52, y: 6'h01};
    vecs[2] = '{x: 6'h02, e: 6'd62, y: 6'h21};
    vecs[3] = '{x: 6'h02, e: 6'd63, y: 6'h01};
    vecs[4] = '{x: 6'h00, e: 6'd0,  y: 6'h01};
    vecs[5] = '{x: 6'h00, e: 6'd5,  y: 6'h00};

    // Reset then idle
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_e      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready",  int'(bus.in_ready),  1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_y",     int'(bus.out_y),     0);
    chk("reset_busy",      int'(bus.busy),      0);

    // Directed vectors, including latency
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, vecs[i].e, y, lat);
      chk($sformatf("vec%0d_y", i),   int'(y), int'(vecs[i].y));
      chk($sformatf("vec%0d_lat", i), lat,     EXP_W);
    end

    // Backpressure with a competing operand held on the input
    bus.in_x      = 6'h02;
    bus.in_e      = 6'd52;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_busy_run", int'(bus.busy), 1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("bp_lat", lat, EXP_W);
    bus.in_x     = 6'h03;
    bus.in_e     = 6'd52;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", int'(bus.out_valid), 1);
      chk("bp_hold_y",     int'(bus.out_y),     'h15);
      chk("bp_hold_ready", int'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_hs_valid", int'(bus.out_valid), 0);
    chk("bp_hs_ready", int'(bus.in_ready),  1);
    chk("bp_hs_busy",  int'(bus.busy),      0);
    chk("bp_hs_y",     int'(bus.out_y),     'h15);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second_busy", int'(bus.busy), 1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("bp_second_lat", lat, EXP_W);
    chk("bp_second_y", int'(bus.out_y), pow_ref(3, 52));
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of a run
    bus.in_x     = 6'h05;
    bus.in_e     = 6'd33;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", int'(bus.in_ready),  1);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy",  int'(bus.busy),      0);
    chk("mid_rst_y",     int'(bus.out_y),     0);
    seen = 0;
    for (int c = 0; c < EXP_W + 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("mid_rst_no_valid", seen, 0);
    run_op(6'h02, 6'd62, y, lat);
    chk("post_rst_y", int'(y), 'h21);

    // Sweep of all bases at e=52, two independent references
    for (int x = 0; x < 64; x++) begin
      run_op(6'(x), 6'd52, y, lat);
      chk($sformatf("sweep_x%0d", x),     int'(y), pow_ref(x, 52));
      chk($sformatf("sweep_log_x%0d", x), int'(y), pow_log(x, 52));
      if (x % 16 == 0) chk($sformatf("sweep_lat_x%0d", x), lat, EXP_W);
    end

    // Random operands
    for (int n = 0; n < 40; n++) begin
      int rx;
      int re;
      rx = $urandom_range(0, 63);
      re = $urandom_range(0, 63);
      run_op(6'(rx), 6'(re), y, lat);
      chk($sformatf("rand_x%0d_e%0d", rx, re), int'(y), pow_ref(rx, re));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
